// File: rtl/rsa_operand_loader.sv
// ---------------------------------------------------------------------------
// rsa_operand_loader
//
// Upstream feeder for the modular exponentiator. Collects WORD_W-bit words
// from a valid/ready stream and assembles three OP_W-bit operands in the
// fixed order x, e, m (least-significant word of each operand first). When
// all three are loaded, it issues a one-cycle start pulse. The operands are
// then held stable until the exponentiator reports done.
//
// Optional feature (compile-time macro RSA_LOADER_MODCHECK_EN):
//   An even modulus is rejected. No start pulse is issued, err is raised and
//   the loader returns to waiting for x. err stays set until the next word is
//   accepted. When the macro is undefined, err is tied low.
//
// Parameters:
//   WORD_W  stream word width
//   OP_W    operand width; must be an exact multiple of WORD_W, at least two words
//
// Ports:
//   clk        in   rising-edge clock
//   resetn     in   asynchronous active-low reset
//   in_valid   in   upstream word valid
//   in_data    in   upstream word
//   in_ready   out  loader can accept a word (LOAD_X/LOAD_E/LOAD_M only)
//   x, e, m    out  base, exponent and modulus operands
//   exp_start  out  one-cycle start pulse to the exponentiator
//   exp_done   in   exponentiator finished (only honoured while waiting)
//   busy       out  high from the first accepted x word until done
//   err        out  even modulus rejected (always 0 without the macro)
// ---------------------------------------------------------------------------
module rsa_operand_loader #(
  parameter int WORD_W = 32,
  parameter int OP_W   = 512
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              in_valid,
  input  logic [WORD_W-1:0] in_data,
  output logic              in_ready,
  output logic [OP_W-1:0]   x,
  output logic [OP_W-1:0]   e,
  output logic [OP_W-1:0]   m,
  output logic              exp_start,
  input  logic              exp_done,
  output logic              busy,
  output logic              err
);

  localparam int WORDS = OP_W / WORD_W;
  localparam int CNT_W = (WORDS > 1) ? $clog2(WORDS) : 1;

  localparam logic [2:0] LOAD_X = 3'd0;
  localparam logic [2:0] LOAD_E = 3'd1;
  localparam logic [2:0] LOAD_M = 3'd2;
  localparam logic [2:0] FIRE   = 3'd3;
  localparam logic [2:0] WAIT   = 3'd4;

  logic [2:0]       state;
  logic [CNT_W-1:0] count;
  logic             accept;
  logic             last_word;
  logic             start_ok;
  logic [OP_W-1:0]  x_shift;
  logic [OP_W-1:0]  e_shift;
  logic [OP_W-1:0]  m_shift;

  // Ready is a pure decode of the registered state, so it never depends
  // combinationally on in_valid.
  assign in_ready  = (state == LOAD_X) || (state == LOAD_E) || (state == LOAD_M);
  assign accept    = in_valid & in_ready;
  assign last_word = (count == CNT_W'(WORDS - 1));

  // New words enter at the top. After WORDS shifts, the first word received
  // has moved down into the least-significant slot.
  assign x_shift = {in_data, x[OP_W-1:WORD_W]};
  assign e_shift = {in_data, e[OP_W-1:WORD_W]};
  assign m_shift = {in_data, m[OP_W-1:WORD_W]};

  // exp_start is registered. Whether to fire must therefore be known on the
  // final m accept. m_shift[0] is the modulus LSB that FIRE will see.
`ifdef RSA_LOADER_MODCHECK_EN
  assign start_ok = m_shift[0];
`else
  assign start_ok = 1'b1;
`endif

  // Main sequencer: operand shifting, word counting, state and busy.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= LOAD_X;
      count     <= '0;
      x         <= '0;
      e         <= '0;
      m         <= '0;
      exp_start <= 1'b0;
      busy      <= 1'b0;
    end else begin
      exp_start <= 1'b0;
      case (state)
        LOAD_X: begin
          if (accept) begin
            x <= x_shift;
            if (count == '0) begin
              busy <= 1'b1;
            end
            if (last_word) begin
              state <= LOAD_E;
            end
          end
        end
        LOAD_E: begin
          if (accept) begin
            e <= e_shift;
            if (last_word) begin
              state <= LOAD_M;
            end
          end
        end
        LOAD_M: begin
          if (accept) begin
            m <= m_shift;
            if (last_word) begin
              state     <= FIRE;
              exp_start <= start_ok;
            end
          end
        end
        FIRE: begin
          state <= WAIT;
`ifdef RSA_LOADER_MODCHECK_EN
          if (!m[0]) begin
            state <= LOAD_X;
            busy  <= 1'b0;
          end
`endif
        end
        WAIT: begin
          if (exp_done) begin
            state <= LOAD_X;
            busy  <= 1'b0;
          end
        end
        default: state <= LOAD_X;
      endcase

      if (accept) begin
        count <= last_word ? '0 : count + CNT_W'(1);
      end
    end
  end

`ifdef RSA_LOADER_MODCHECK_EN
  // Sticky reject flag. It is set when FIRE sees an even modulus and cleared
  // by the next accepted word.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      err <= 1'b0;
    end else if (state == FIRE && !m[0]) begin
      err <= 1'b1;
    end else if (accept) begin
      err <= 1'b0;
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule
